// File: rtl/gshare_checkpoint_predictor.sv
// Gshare branch direction predictor with speculative global history and an in-order
// checkpoint queue; the counter RAM is filled by a sweep after every reset.
module gshare_checkpoint_predictor #(
    parameter int CNT_WIDTH   = 2,
    parameter int CNT_INIT    = 1,
    parameter int INDEX_WIDTH = 10,
    parameter int GHR_WIDTH   = 8,
    parameter int CKPT_DEPTH  = 4,
    localparam int TAGW       = $clog2(CKPT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 PL_stall,
    input  logic                 pred_req,
    input  logic [31:0]          pred_pc,
    output logic                 pred_ready,
    output logic                 pred_taken,
    output logic [CNT_WIDTH-1:0] pred_count,
    output logic [TAGW-1:0]      pred_tag,
    input  logic                 resolve_en,
    input  logic [TAGW-1:0]      resolve_tag,
    input  logic                 resolve_taken,
    input  logic                 resolve_mispredict,
    output logic                 busy_init,
    output logic                 proto_err
);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    localparam logic [TAGW:0] FULL_C = (TAGW+1)'(CKPT_DEPTH);

    function automatic logic [CNT_WIDTH-1:0] sat_update(input logic [CNT_WIDTH-1:0] cnt,
                                                        input logic up);
        if (up) begin
            return (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);
        end else begin
            return (cnt == {CNT_WIDTH{1'b0}}) ? cnt : cnt - CNT_WIDTH'(1);
        end
    endfunction

    state_e                 state_r;
    logic [INDEX_WIDTH-1:0] sweep_idx_r;
    logic [GHR_WIDTH-1:0]   ghr_r;
    logic [TAGW-1:0]        head_r;
    logic [TAGW-1:0]        tail_r;
    logic [TAGW:0]          occ_r;
    logic                   proto_err_r;
    logic [INDEX_WIDTH-1:0] slot_idx_r [CKPT_DEPTH];
    logic [CNT_WIDTH-1:0]   slot_cnt_r [CKPT_DEPTH];
    logic [GHR_WIDTH-1:0]   slot_ghr_r [CKPT_DEPTH];
    logic [CNT_WIDTH-1:0]   table_r    [2**INDEX_WIDTH];

    logic                   run_s;
    logic [INDEX_WIDTH-1:0] index_s;
    logic [CNT_WIDTH-1:0]   rd_cnt_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   res_valid_s;
    logic                   tbl_we_s;
    logic [INDEX_WIDTH-1:0] tbl_widx_s;
    logic [CNT_WIDTH-1:0]   tbl_wdata_s;
    logic                   unused_pc_s;

    assign unused_pc_s = ^{pred_pc[31:INDEX_WIDTH+2], pred_pc[1:0]};
    assign run_s       = (state_r == ST_RUN);
    assign index_s     = pred_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_r);
    assign rd_cnt_s    = table_r[index_s];
    // A mispredict rewinds history this cycle, so no new lookup may use the stale GHR.
    assign ready_s     = run_s && (occ_r < FULL_C) && !(resolve_en && resolve_mispredict);
    assign accept_s    = pred_req && ready_s && !PL_stall;
    assign res_valid_s = run_s && resolve_en && (occ_r != {(TAGW+1){1'b0}})
                         && (resolve_tag == head_r);

    assign pred_ready  = ready_s;
    assign pred_taken  = run_s ? rd_cnt_s[CNT_WIDTH-1] : 1'b0;
    assign pred_count  = run_s ? rd_cnt_s : {CNT_WIDTH{1'b0}};
    assign pred_tag    = run_s ? tail_r : {TAGW{1'b0}};
    assign busy_init   = (state_r == ST_INIT);
    assign proto_err   = proto_err_r;

    // Single counter write port shared by the init sweep and branch resolution.
    always_comb begin
        tbl_we_s    = 1'b0;
        tbl_widx_s  = {INDEX_WIDTH{1'b0}};
        tbl_wdata_s = {CNT_WIDTH{1'b0}};
        if (state_r == ST_INIT) begin
            tbl_we_s    = 1'b1;
            tbl_widx_s  = sweep_idx_r;
            tbl_wdata_s = CNT_WIDTH'(CNT_INIT);
        end else begin
            tbl_we_s    = res_valid_s;
            tbl_widx_s  = slot_idx_r[head_r];
            tbl_wdata_s = sat_update(slot_cnt_r[head_r], resolve_taken);
        end
    end

    // Counter RAM: no reset, contents established by the sweep.
    always_ff @(posedge clk) begin
        if (tbl_we_s) begin
            table_r[tbl_widx_s] <= tbl_wdata_s;
        end
    end

    // Sweep FSM, speculative history and checkpoint queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            sweep_idx_r <= {INDEX_WIDTH{1'b0}};
            ghr_r       <= {GHR_WIDTH{1'b0}};
            head_r      <= {TAGW{1'b0}};
            tail_r      <= {TAGW{1'b0}};
            occ_r       <= {(TAGW+1){1'b0}};
            proto_err_r <= 1'b0;
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                slot_idx_r[i] <= {INDEX_WIDTH{1'b0}};
                slot_cnt_r[i] <= {CNT_WIDTH{1'b0}};
                slot_ghr_r[i] <= {GHR_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_INIT: begin
                    sweep_idx_r <= sweep_idx_r + INDEX_WIDTH'(1);
                    if (sweep_idx_r == {INDEX_WIDTH{1'b1}}) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN:  state_r <= ST_RUN;
                default: state_r <= ST_INIT;
            endcase

            if (resolve_en && !res_valid_s) begin
                proto_err_r <= 1'b1;
            end

            if (accept_s) begin
                slot_idx_r[tail_r] <= index_s;
                slot_cnt_r[tail_r] <= rd_cnt_s;
                slot_ghr_r[tail_r] <= ghr_r;
            end

            if (res_valid_s && resolve_mispredict) begin
                ghr_r  <= {slot_ghr_r[head_r][GHR_WIDTH-2:0], resolve_taken};
                head_r <= head_r + TAGW'(1);
                tail_r <= head_r + TAGW'(1);
                occ_r  <= {(TAGW+1){1'b0}};
            end else begin
                if (accept_s) begin
                    ghr_r  <= {ghr_r[GHR_WIDTH-2:0], rd_cnt_s[CNT_WIDTH-1]};
                    tail_r <= tail_r + TAGW'(1);
                end
                if (res_valid_s) begin
                    head_r <= head_r + TAGW'(1);
                end
                if (accept_s && !res_valid_s) begin
                    occ_r <= occ_r + (TAGW+1)'(1);
                end else if (!accept_s && res_valid_s) begin
                    occ_r <= occ_r - (TAGW+1)'(1);
                end
            end
        end
    end

endmodule
